// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Two-requester round-robin arbiter feeding a single registered writeback beat
// to the register-file write port.
//
// Handshake: every port uses valid/ready. A beat moves only on a rising clock
// edge where tvalid=1 and tready=1. A source never waits for tready before
// raising tvalid. The sN_tready outputs are combinational in sN_tvalid,
// m_tready and invalidate. The m_tvalid/m_tdata outputs come straight from
// flops.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-low reset (0 = reset, 1 = run)
//   s0_tvalid   requester 0 (ALU path) beat valid
//   s0_tready   requester 0 beat accepted this cycle
//   s0_tdata    requester 0 beat
//   s1_tvalid   requester 1 (load/CSR path) beat valid
//   s1_tready   requester 1 beat accepted this cycle
//   s1_tdata    requester 1 beat
//   m_tvalid    registered beat valid toward the register file
//   m_tready    register-file write port accepts
//   m_tdata     registered beat
//   invalidate  pipeline flush: drops the held beat and blocks acceptance
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_tvalid,
  output logic                   s0_tready,
  input  logic [TDATA_WIDTH-1:0] s0_tdata,
  input  logic                   s1_tvalid,
  output logic                   s1_tready,
  input  logic [TDATA_WIDTH-1:0] s1_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  input  logic                   invalidate
);

  // Index of the requester that won the most recent input transfer.
  // Resets to 1 so requester 0 wins the first contention.
  logic last_winner;

  logic out_free;
  logic grant0;
  logic grant1;
  logic take0;
  logic take1;

  always_comb begin
    // The output register can accept a new beat when it is empty or when
    // its current beat leaves on this same edge (back-to-back reload).
    out_free = !m_tvalid || m_tready;

    // Round-robin: a lone requester always wins; under contention the
    // requester that did not win last time wins.
    grant0 = s0_tvalid && (!s1_tvalid || last_winner);
    grant1 = s1_tvalid && (!s0_tvalid || !last_winner);

    // Readies are forced low while in reset and during a flush. grant0 and
    // grant1 are mutually exclusive, so at most one ready is ever high.
    take0 = grant0 && out_free && !invalidate && rst;
    take1 = grant1 && out_free && !invalidate && rst;
  end

  assign s0_tready = take0;
  assign s1_tready = take1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      last_winner <= 1'b1;
    end else if (invalidate) begin
      // Flush drops the held beat. last_winner is left alone so fairness
      // carries across the flush.
      m_tvalid <= 1'b0;
    end else if (take0) begin
      m_tvalid    <= 1'b1;
      m_tdata     <= s0_tdata;
      last_winner <= 1'b0;
    end else if (take1) begin
      m_tvalid    <= 1'b1;
      m_tdata     <= s1_tdata;
      last_winner <= 1'b1;
    end else if (m_tready) begin
      // Beat drained with nothing new to load: empty the register.
      // m_tdata keeps its last value.
      m_tvalid <= 1'b0;
    end
  end

endmodule
